// File: rtl/guitar_pkg.sv
// guitar_pkg: shared types and helpers for the guitar control datapath.
//   state_e       - note FSM states (IDLE, SOUNDING)
//   STRUM_POS/NEG - strum_dir encoding (1 = up-strum, 0 = down-strum)
//   code_width()  - ceil(log2(n)), never less than 1; sizes codes and counters
package guitar_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SOUNDING = 1'b1
  } state_e;

  localparam logic STRUM_POS = 1'b1;
  localparam logic STRUM_NEG = 1'b0;

  function automatic int unsigned code_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/strum_debouncer.sv
// strum_debouncer: 2-FF synchroniser, debounce counter and rising-edge
// detector for one strummer contact.
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   raw_in in  asynchronous, bouncy contact
//   level  out debounced level (registered)
//   rise   out high for one cycle after level goes 0 -> 1
// The level changes only after DEBOUNCE_CYCLES consecutive synchronised
// samples that disagree with it.
module strum_debouncer
  import guitar_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = code_width(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The sample that completes the run flips the level on that same edge,
  // hence the compare against DEBOUNCE_CYCLES-1 on the pre-increment count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/strum_note_ctrl.sv
// strum_note_ctrl: fret/strum control-signal generator for the tone block.
//   clk            in  system clock
//   reset          in  synchronous active-high reset
//   switches       in  NUM_FRETS fret switches (asynchronous), bit i = fret i
//   strummer_pos   in  up-strum contact (asynchronous, bouncy)
//   strummer_neg   in  down-strum contact (asynchronous, bouncy)
//   control_signal out registered note code, width code_width(NUM_FRETS)
//   strum_dir      out direction of last accepted strum (1 = pos, 0 = neg)
//   note_start     out one-cycle pulse per accepted strum
//   note_on        out high for SUSTAIN_CYCLES cycles after each strum
// Build option: define LEGATO_EN to let fret changes during a sounding note
// update control_signal without a new strum (hammer-on / pull-off).
module strum_note_ctrl
  import guitar_pkg::*;
#(
  parameter int unsigned NUM_FRETS       = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SUSTAIN_CYCLES  = 1000,
  parameter int unsigned DEFAULT_CODE    = NUM_FRETS - 1,
  localparam int unsigned CODE_W         = code_width(NUM_FRETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FRETS-1:0] switches,
  input  logic                 strummer_pos,
  input  logic                 strummer_neg,
  output logic [CODE_W-1:0]    control_signal,
  output logic                 strum_dir,
  output logic                 note_start,
  output logic                 note_on
);

  localparam int unsigned SUS_W = code_width(SUSTAIN_CYCLES + 1);

  logic [NUM_FRETS-1:0] sw_sync1_q, sw_sync2_q;
  logic                 lvl_pos, lvl_neg;
  logic                 rise_pos, rise_neg;
  logic                 trigger;
  logic [CODE_W-1:0]    enc;

  state_e               state_q, state_d;
  logic [SUS_W-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 dir_q, dir_d;
  logic                 start_q, start_d;

  strum_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_pos (
    .clk   (clk),
    .reset (reset),
    .raw_in(strummer_pos),
    .level (lvl_pos),
    .rise  (rise_pos)
  );

  strum_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_neg (
    .clk   (clk),
    .reset (reset),
    .raw_in(strummer_neg),
    .level (lvl_neg),
    .rise  (rise_neg)
  );

  assign trigger = rise_pos | rise_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= switches;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Ascending scan: later (higher) set bits overwrite, so the highest fret wins.
  always_comb begin
    enc = CODE_W'(DEFAULT_CODE);
    for (int unsigned i = 0; i < NUM_FRETS; i++) begin
      if (sw_sync2_q[i]) enc = CODE_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    dir_d   = dir_q;
    start_d = 1'b0;
    // A trigger in either state (including the expiry cycle) starts a fresh
    // note; simultaneous edges report the up-strum.
    if (trigger) begin
      state_d = SOUNDING;
      code_d  = enc;
      dir_d   = rise_pos ? STRUM_POS : STRUM_NEG;
      start_d = 1'b1;
      cnt_d   = SUS_W'(SUSTAIN_CYCLES - 1);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SOUNDING: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - SUS_W'(1);
          end
`ifdef LEGATO_EN
          if (enc != code_q) code_d = enc;
`else
          code_d = code_q;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      dir_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      start_q <= start_d;
    end
  end

  assign control_signal = code_q;
  assign strum_dir      = dir_q;
  assign note_start     = start_q;
  assign note_on        = (state_q == SOUNDING);

endmodule

// File: doc/strum_note_ctrl.md
Name: strum_note_ctrl

Overview:
Parametrised successor to the fret/strum control-signal generator in the guitar datapath. The block synchronises and debounces both strummer directions and detects strum edges. On each strum it latches a priority-encoded fret code and runs a sustain timer, so the downstream tone generator gets a note code plus note-on/note-start strobes. It sits between the board inputs (fret switches, strummer contacts) and the tone/synth block.

Parameters:
NUM_FRETS, 7, number of fret switches; code width CODE_W = clog2(NUM_FRETS), minimum 1
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change a debounced strummer level (≥1)
SUSTAIN_CYCLES, 1000, length of note_on per strum, in clk cycles (≥1)
DEFAULT_CODE, NUM_FRETS-1, code latched when no fret switch is pressed

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
switches  in  NUM_FRETS  fret switches, bit i = fret i, asynchronous to clk
strummer_pos  in  1  up-strum contact, asynchronous, bouncy
strummer_neg  in  1  down-strum contact, asynchronous, bouncy
control_signal  out  CODE_W  registered note code
strum_dir  out  1  direction of last accepted strum: 1 = pos, 0 = neg
note_start  out  1  one-cycle pulse per accepted strum
note_on  out  1  high while note sustains

Behaviour:
- Reset (sampled at clk edge while reset=1): control_signal=0, strum_dir=0, note_start=0, note_on=0, FSM=IDLE, sync/debounce/edge registers and counters=0. Reset mid-note aborts the note on that edge.
- Synchronisers: switches, strummer_pos and strummer_neg each pass through a 2-FF synchroniser.
- Debounce, per strummer:
  - Counter increments on each edge where the synchronised value differs from the debounced level; it clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- Edge detect: rise_x = debounced_x & ~debounced_x_prev; trigger = rise_pos | rise_neg.
  - Both rising together produce one trigger, with strum_dir=1.
  - Falling edges are ignored.
- Latency: for an input clean-high before edge 1, the debounced level flips at edge 2+DEBOUNCE_CYCLES, and note_start/note_on/control_signal update at edge 3+DEBOUNCE_CYCLES.
- Fret encode (combinational on synchronised switches): the index of the highest set bit wins. All-zero gives DEFAULT_CODE. Multiple bits are legal; the highest wins.
- FSM, IDLE/SOUNDING. Sustain counter width is clog2(SUSTAIN_CYCLES+1).
  - IDLE + trigger -> SOUNDING: latch code and strum_dir, note_start=1, note_on=1, counter=SUSTAIN_CYCLES-1.
  - SOUNDING, no trigger, counter>0: counter decrements, note_start=0.
  - SOUNDING, no trigger, counter=0 -> IDLE: note_on=0. note_on is therefore high for exactly SUSTAIN_CYCLES cycles.
  - SOUNDING + trigger (retrigger): relatch code/dir, pulse note_start, reload counter. This includes the expiry cycle, where retrigger beats expiry and note_on stays high with no gap.
- control_signal and strum_dir hold their last latched values in IDLE.
- Switch changes without a trigger do not alter control_signal.

Optional Feature:
Macro LEGATO_EN.
- Defined: in SOUNDING with no trigger, if the encoded fret differs from control_signal, control_signal takes the new code on the next edge (hammer-on/pull-off). This does not pulse note_start and does not reload the counter. IDLE behaviour is unchanged.
- Undefined: code changes only on trigger, as above.

Decomposition:
- Package guitar_pkg:
  - state enum {IDLE, SOUNDING}
  - function for code width (clog2 with min 1)
  - strum_dir encoding constants STRUM_POS=1, STRUM_NEG=0
- Sub-module strum_debouncer (parameter DEBOUNCE_CYCLES; ports clk, reset, raw_in, level, rise). It holds the 2-FF sync, debounce counter and edge detect, and is instantiated twice.
- Fret encoder and FSM live in the top module.

Test Plan:
- Reset: hold reset 2 cycles during a strum -> all outputs 0. After release with strummer_pos held high, note_start occurs at edge DEBOUNCE_CYCLES+3 after release.
- Bounce rejection, DEBOUNCE_CYCLES=16: toggle strummer_neg every 5 cycles for 100 cycles, then hold high -> no note_start during bounce; exactly one note_start afterwards, strum_dir=0.
- Priority/default:
  - switches=7'b0100100 on strum -> control_signal=5.
  - switches=0 on strum -> control_signal=6.
  - Change switches to 7'b0000001 with no strum -> control_signal stays 6 (LEGATO_EN off).
- Sustain, SUSTAIN_CYCLES=10: single strum -> note_on high exactly 10 cycles, then 0, state IDLE.
- Retrigger at expiry: second trigger lands on the counter=0 cycle -> note_on continuous, second note_start pulse, new code latched, note_on lasts a further 10 cycles.
- Simultaneous pos+neg clean edges in the same cycle -> one note_start, strum_dir=1. With LEGATO_EN defined, a fret change 2→4 mid-note -> control_signal=4 next edge, no note_start, note_on duration unchanged.
